// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Optional feature macro: VEND_TIMEOUT_EN (auto-refund after idle COLLECT).
package vend_pkg;

    localparam int unsigned VEND_PRICE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_COLLECT  = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4,
        ST_REFUND   = 3'd5
    } vend_state_e;

    // Credit carries one extra bit so overpayment up to 2*max coin is representable.
    function automatic int unsigned credit_width(input int unsigned price_width);
        return price_width + 1;
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Saturating credit register: clear has priority over subtract, subtract over add.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_WIDTH  = VEND_PRICE_WIDTH,
    parameter int unsigned CREDIT_WIDTH = PRICE_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    add_i,
    input  logic [PRICE_WIDTH-1:0]  add_val_i,
    input  logic                    sub_i,
    input  logic [PRICE_WIDTH-1:0]  sub_val_i,
    output logic [CREDIT_WIDTH-1:0] credit_o
);

    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic [CREDIT_WIDTH:0]   sum;

    always_comb begin
        sum      = {1'b0, credit_q} + (CREDIT_WIDTH + 1)'(add_val_i);
        credit_d = credit_q;
        if (clr_i) begin
            credit_d = '0;
        end else if (sub_i) begin
            credit_d = credit_q - CREDIT_WIDTH'(sub_val_i);
        end else if (add_i) begin
            credit_d = sum[CREDIT_WIDTH] ? '1 : sum[CREDIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) credit_q <= '0;
        else     credit_q <= credit_d;
    end

    assign credit_o = credit_q;

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction sequencer: price lookup, coin collection, dispense and change/refund.
// Optional feature macro: VEND_TIMEOUT_EN (COLLECT idle timeout -> refund).
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned ITEM_ADDR_WIDTH = 10,
    parameter int unsigned PRICE_WIDTH     = VEND_PRICE_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ITEM_ADDR_WIDTH-1:0] item_selected,
    input  logic                       selection_valid,
    output logic                       price_req,
    output logic [ITEM_ADDR_WIDTH-1:0] price_addr,
    input  logic                       price_rsp_valid,
    input  logic [PRICE_WIDTH-1:0]     price_data,
    input  logic                       in_stock,
    input  logic                       coin_valid,
    input  logic [PRICE_WIDTH-1:0]     coin_value,
    input  logic                       cancel,
    output logic                       dispense_valid,
    output logic [ITEM_ADDR_WIDTH-1:0] dispense_addr,
    input  logic                       dispense_ready,
    output logic                       change_valid,
    output logic [PRICE_WIDTH:0]       change_amount,
    input  logic                       change_ready,
    output logic                       busy,
    output logic                       err_out_of_stock
);

    localparam int unsigned CW = credit_width(PRICE_WIDTH);

    vend_state_e                state_q, state_d;
    logic [ITEM_ADDR_WIDTH-1:0] item_q, item_d;
    logic [PRICE_WIDTH-1:0]     price_q, price_d;
    logic                       price_req_q, price_req_d;
    logic                       err_q, err_d;
    logic [CW-1:0]              credit_q;
    logic                       add_en, sub_en, clr_en;
    logic                       credit_nz, timeout;

`ifdef VEND_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = (state_q != ST_COLLECT || coin_valid) ? '0 : idle_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) idle_cnt_q <= '0;
        else     idle_cnt_q <= idle_cnt_d;
    end

    assign timeout = (state_q == ST_COLLECT) && !coin_valid &&
                     (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    vend_credit_acc #(
        .PRICE_WIDTH (PRICE_WIDTH),
        .CREDIT_WIDTH(CW)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_en),
        .add_i    (add_en),
        .add_val_i(coin_value),
        .sub_i    (sub_en),
        .sub_val_i(price_q),
        .credit_o (credit_q)
    );

    // Credit as it will be after this cycle's coin, so an abort never strands a fresh coin.
    assign credit_nz = (credit_q != '0) || (coin_valid && coin_value != '0);

    always_comb begin
        state_d     = state_q;
        item_d      = item_q;
        price_d     = price_q;
        price_req_d = 1'b0;
        err_d       = 1'b0;
        add_en      = 1'b0;
        sub_en      = 1'b0;
        clr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (selection_valid) begin
                    item_d      = item_selected;
                    price_req_d = 1'b1;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                add_en = coin_valid;
                if (cancel) begin
                    state_d = credit_nz ? ST_REFUND : ST_IDLE;
                end else if (price_rsp_valid) begin
                    if (in_stock) begin
                        price_d = price_data;
                        state_d = ST_COLLECT;
                    end else begin
                        // Coins taken during lookup are returned rather than carried over.
                        err_d   = 1'b1;
                        state_d = credit_nz ? ST_REFUND : ST_IDLE;
                    end
                end
            end
            ST_COLLECT: begin
                add_en = coin_valid;
                if (cancel || timeout) begin
                    state_d = credit_nz ? ST_REFUND : ST_IDLE;
                end else if (credit_q >= CW'(price_q)) begin
                    state_d = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (dispense_ready) begin
                    sub_en  = 1'b1;
                    state_d = (credit_q != CW'(price_q)) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (change_ready) begin
                    clr_en  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            item_q      <= '0;
            price_q     <= '0;
            price_req_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            price_q     <= price_d;
            price_req_q <= price_req_d;
            err_q       <= err_d;
        end
    end

    assign price_req        = price_req_q;
    assign price_addr       = price_req_q ? item_q : '0;
    assign dispense_valid   = (state_q == ST_DISPENSE);
    assign dispense_addr    = dispense_valid ? item_q : '0;
    assign change_valid     = (state_q == ST_CHANGE) || (state_q == ST_REFUND);
    assign change_amount    = change_valid ? credit_q : '0;
    assign busy             = (state_q != ST_IDLE);
    assign err_out_of_stock = err_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: per-cycle reference model plus directed literal checks.
// Honours VEND_TIMEOUT_EN for the idle-timeout scenario.
module tb_vend_ctrl;

    localparam int AW   = 10;
    localparam int PW   = 8;
    localparam int TO   = 16;
    localparam int CMAX = (1 << (PW + 1)) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] item_selected;
    logic          selection_valid;
    logic          price_req;
    logic [AW-1:0] price_addr;
    logic          price_rsp_valid;
    logic [PW-1:0] price_data;
    logic          in_stock;
    logic          coin_valid;
    logic [PW-1:0] coin_value;
    logic          cancel;
    logic          dispense_valid;
    logic [AW-1:0] dispense_addr;
    logic          dispense_ready;
    logic          change_valid;
    logic [PW:0]   change_amount;
    logic          change_ready;
    logic          busy;
    logic          err_out_of_stock;

    always #5 clk = ~clk;

    vend_ctrl #(
        .ITEM_ADDR_WIDTH(AW),
        .PRICE_WIDTH    (PW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .item_selected   (item_selected),
        .selection_valid (selection_valid),
        .price_req       (price_req),
        .price_addr      (price_addr),
        .price_rsp_valid (price_rsp_valid),
        .price_data      (price_data),
        .in_stock        (in_stock),
        .coin_valid      (coin_valid),
        .coin_value      (coin_value),
        .cancel          (cancel),
        .dispense_valid  (dispense_valid),
        .dispense_addr   (dispense_addr),
        .dispense_ready  (dispense_ready),
        .change_valid    (change_valid),
        .change_amount   (change_amount),
        .change_ready    (change_ready),
        .busy            (busy),
        .err_out_of_stock(err_out_of_stock)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is a phase (idle / awaiting price / collecting /
    // vending / returning money) plus an integer purse, updated from the sampled inputs.
    typedef enum int {PH_IDLE, PH_PRICE, PH_COLLECT, PH_VEND, PH_RETURN} phase_t;
    phase_t m_phase = PH_IDLE;
    int     m_credit = 0, m_price = 0, m_item = 0, m_idle = 0;
    bit     m_req = 0, m_err = 0, m_live = 0, m_enough = 0, m_timed = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = PH_IDLE; m_credit = 0; m_price = 0; m_item = 0;
            m_idle = 0; m_req = 0; m_err = 0; m_live = 1;
        end else begin
            m_req = 0;
            m_err = 0;
            case (m_phase)
                PH_IDLE: if (selection_valid) begin
                    m_item = int'(item_selected); m_req = 1; m_phase = PH_PRICE;
                end
                PH_PRICE: begin
                    if (coin_valid) m_credit = sat(m_credit + int'(coin_value));
                    if (cancel) m_phase = (m_credit > 0) ? PH_RETURN : PH_IDLE;
                    else if (price_rsp_valid) begin
                        if (in_stock) begin
                            m_price = int'(price_data); m_idle = 0; m_phase = PH_COLLECT;
                        end else begin
                            m_err = 1; m_phase = (m_credit > 0) ? PH_RETURN : PH_IDLE;
                        end
                    end
                end
                PH_COLLECT: begin
                    m_enough = (m_credit >= m_price);
                    m_idle   = coin_valid ? 0 : m_idle + 1;
`ifdef VEND_TIMEOUT_EN
                    m_timed  = (m_idle == TO);
`else
                    m_timed  = 0;
`endif
                    if (coin_valid) m_credit = sat(m_credit + int'(coin_value));
                    if (cancel || m_timed) m_phase = (m_credit > 0) ? PH_RETURN : PH_IDLE;
                    else if (m_enough) m_phase = PH_VEND;
                end
                PH_VEND: if (dispense_ready) begin
                    m_credit = m_credit - m_price;
                    m_phase  = (m_credit > 0) ? PH_RETURN : PH_IDLE;
                end
                PH_RETURN: if (change_ready) begin
                    m_credit = 0; m_phase = PH_IDLE;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", busy, m_phase != PH_IDLE);
            chk("price_req", price_req, m_req);
            chk("price_addr", price_addr, m_req ? m_item : 0);
            chk("err_out_of_stock", err_out_of_stock, m_err);
            chk("dispense_valid", dispense_valid, m_phase == PH_VEND);
            chk("dispense_addr", dispense_addr, (m_phase == PH_VEND) ? m_item : 0);
            chk("change_valid", change_valid, m_phase == PH_RETURN);
            chk("change_amount", change_amount, (m_phase == PH_RETURN) ? m_credit : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic select_item(input int addr);
        item_selected = AW'(addr); selection_valid = 1'b1;
        tick();
        selection_valid = 1'b0;
    endtask

    task automatic respond(input int price, input bit stock);
        price_data = PW'(price); in_stock = stock; price_rsp_valid = 1'b1;
        tick();
        price_rsp_valid = 1'b0;
    endtask

    task automatic coin(input int v);
        coin_value = PW'(v); coin_valid = 1'b1;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic wait_dispense(input int budget);
        int k = 0;
        while (!dispense_valid && k < budget) begin tick(); k++; end
        chk("dispense_wait", dispense_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; item_selected = '0; selection_valid = 1'b0; price_rsp_valid = 1'b0;
        price_data = '0; in_stock = 1'b0; coin_valid = 1'b0; coin_value = '0;
        cancel = 1'b0; dispense_ready = 1'b0; change_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_dispense_valid", dispense_valid, 0);
        chk("reset_change_valid", change_valid, 0);
        chk("reset_price_req", price_req, 0);

        // Exact payment, no change
        select_item('h123);
        chk("t1_price_req", price_req, 1);
        chk("t1_price_addr", price_addr, 'h123);
        respond(50, 1'b1);
        coin(25);
        coin(25);
        chk("t1_no_dispense_yet", dispense_valid, 0);
        tick();
        chk("t1_dispense_valid", dispense_valid, 1);
        chk("t1_dispense_addr", dispense_addr, 'h123);
        dispense_ready = 1'b1; tick(); dispense_ready = 1'b0;
        chk("t1_idle_busy", busy, 0);
        chk("t1_no_change", change_valid, 0);

        // Overpayment, change held while actuator stalls
        select_item('h045);
        respond(30, 1'b1);
        coin(25);
        coin(10);
        wait_dispense(5);
        dispense_ready = 1'b1; tick(); dispense_ready = 1'b0;
        chk("t2_change_valid", change_valid, 1);
        chk("t2_change_amount", change_amount, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_change_hold", change_amount, 5);
        end
        change_ready = 1'b1; tick(); change_ready = 1'b0;
        chk("t2_idle", busy, 0);

        // Out of stock
        select_item('h001);
        respond(0, 1'b0);
        chk("t3_err_pulse", err_out_of_stock, 1);
        chk("t3_busy", busy, 0);
        tick();
        chk("t3_err_cleared", err_out_of_stock, 0);
        chk("t3_no_dispense", dispense_valid, 0);

        // Coin and cancel together: coin counted into refund
        select_item('h007);
        respond(100, 1'b1);
        coin(20);
        coin_value = 8'd10; coin_valid = 1'b1; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
        chk("t4_refund_valid", change_valid, 1);
        chk("t4_refund_amount", change_amount, 30);
        change_ready = 1'b1; tick(); change_ready = 1'b0;

        // Reselection ignored; reset during dispense
        select_item('h0AB);
        respond(40, 1'b1);
        select_item('h002);
        coin(40);
        wait_dispense(5);
        chk("t5_dispense_addr", dispense_addr, 'h0AB);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_rst_dispense_valid", dispense_valid, 0);
        chk("t5_rst_dispense_addr", dispense_addr, 0);
        chk("t5_rst_change_valid", change_valid, 0);
        chk("t5_rst_busy", busy, 0);

        // Idle timeout in COLLECT
        select_item('h009);
        respond(50, 1'b1);
        coin(10);
`ifdef VEND_TIMEOUT_EN
        begin
            int k = 0;
            while (!change_valid && k < 40) begin tick(); k++; end
            chk("t6_timeout_cycles", k, TO);
            chk("t6_timeout_amount", change_amount, 10);
        end
`else
        repeat (100) tick();
        chk("t6_no_timeout_refund", change_valid, 0);
        chk("t6_still_busy", busy, 1);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t6_cancel_amount", change_amount, 10);
`endif
        change_ready = 1'b1; tick(); change_ready = 1'b0;
        chk("t6_idle", busy, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Transaction sequencer for the vending machine. It takes a registered selection (item_selected/selection_valid) from the item-select stage and looks up the item's price and stock. It then accumulates inserted coins, drives the dispense handshake, and returns change or a refund. It sits between the item-select stage, the price/stock table, the coin acceptor and the dispense/change actuators.

Parameters:
ITEM_ADDR_WIDTH, 10, width of the item address.
PRICE_WIDTH, 8, width of price, coin value and change values.
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-refund (used only with VEND_TIMEOUT_EN).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
item_selected  input  ITEM_ADDR_WIDTH  selected item address.
selection_valid  input  1  one-cycle pulse: new selection.
price_req  output  1  one-cycle lookup request.
price_addr  output  ITEM_ADDR_WIDTH  lookup address.
price_rsp_valid  input  1  lookup response strobe (any latency ≥1 cycle).
price_data  input  PRICE_WIDTH  item price.
in_stock  input  1  item available; sampled with price_rsp_valid.
coin_valid  input  1  one-cycle coin pulse.
coin_value  input  PRICE_WIDTH  coin value.
cancel  input  1  user cancel pulse.
dispense_valid  output  1  dispense request, held until accepted.
dispense_addr  output  ITEM_ADDR_WIDTH  item to dispense.
dispense_ready  input  1  actuator accept.
change_valid  output  1  change/refund request, held until accepted.
change_amount  output  PRICE_WIDTH+1  amount to return.
change_ready  input  1  change actuator accept.
busy  output  1  high whenever state != IDLE.
err_out_of_stock  output  1  one-cycle pulse when the looked-up item is not in stock.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; credit=0; all outputs 0. Reset mid-transaction aborts it with no refund issued.
- Registers: item_q (ITEM_ADDR_WIDTH), price_q (PRICE_WIDTH), credit (PRICE_WIDTH+1, saturates at all-ones).
- IDLE:
  - selection_valid → latch item_q; price_req=1 for one cycle with price_addr=item_selected; go to LOOKUP.
  - Coins in IDLE are ignored (not credited).
- LOOKUP: wait for price_rsp_valid.
  - in_stock=0 → pulse err_out_of_stock; go to IDLE.
  - in_stock=1 → latch price_q; go to COLLECT.
  - Coins arriving during LOOKUP are credited.
  - cancel → REFUND if credit>0, else IDLE.
- COLLECT:
  - coin_valid → credit += coin_value (saturating).
  - Next cycle, credit ≥ price_q → DISPENSE.
  - cancel → REFUND.
  - Coin and cancel in the same cycle: the coin is credited first, then REFUND returns the total.
- DISPENSE: dispense_valid=1 and dispense_addr=item_q, held stable until dispense_ready.
  - On handshake: credit -= price_q; go to CHANGE if the remainder is >0, else IDLE.
  - Coins and cancel are ignored in this state.
- CHANGE / REFUND: change_valid=1 and change_amount=credit, held until change_ready.
  - On handshake: credit=0; go to IDLE.
- selection_valid is ignored whenever state != IDLE; re-selection requires cancel first.
- Latency: selection_valid → price_req is registered, visible the next cycle. Credit update is 1 cycle. The exact-price coin → dispense_valid takes 2 cycles.
- State encoding: IDLE=0, LOOKUP=1, COLLECT=2, DISPENSE=3, CHANGE=4, REFUND=5.

Optional Feature:
VEND_TIMEOUT_EN:
- Defined: a counter counts cycles in COLLECT with no coin_valid and resets on any coin. Reaching TIMEOUT_CYCLES → REFUND, or IDLE if credit=0.
- Undefined: no counter; COLLECT waits indefinitely.

Decomposition:
- Package vend_pkg: state enum/localparams, PRICE_WIDTH default, credit width constant.
- Sub-module vend_credit_acc: saturating credit accumulator with add, subtract and clear controls. Instantiated once.

Test Plan:
1. Reset, select 10'h123, price response 8'd50 with in_stock=1, coins 25+25 → dispense_valid with addr 10'h123; after dispense_ready no change; back to IDLE, busy=0.
2. Price 8'd30, coins 25+10 → dispense, then change_valid with change_amount=5; hold change_ready low 3 cycles and confirm value stays stable.
3. Select 10'h001, in_stock=0 → err_out_of_stock pulses exactly 1 cycle; no dispense; IDLE.
4. Price 8'd100, coin 20, then coin 10 and cancel in the same cycle → REFUND with change_amount=30.
5. Second selection_valid (10'h002) during COLLECT ignored; dispense_addr stays at the first item; rst asserted during DISPENSE → all outputs 0 next cycle.
6. With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=16: coin 10, then idle 16 cycles → refund 10; without the macro, no refund after 100 cycles.
